fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the PC, the instruction-memory read port and the IF/ID register.
// It also handles hazard stalls through a one-entry skid buffer, flushes on redirect, halt, and fault flagging.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] redirectPc,
  input  logic        stall,
  input  logic        halt,
  output logic        imemRd,
  output logic [15:0] imemAddr,
  input  logic        imemDone,
  input  logic [15:0] imemData,
  output logic [15:0] instrOut,
  output logic [15:0] pcOut,
  output logic        instrValid,
  output logic        err
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    BUF    = 2'd1,
    DROP   = 2'd2,
    HALTED = 2'd3
  } stateT;

  stateT       state, stateNext;
  logic [15:0] pc, pcNext;
  logic [15:0] instrNext, pcOutNext;
  logic        validNext, errNext;
  logic [15:0] skidInstr, skidInstrNext;
  logic [15:0] skidPc, skidPcNext;
  logic [16:0] pcPlus2;
  logic        pcWrap;

  // The carry out of the increment marks the FFFE -> 0000 wrap.
  assign pcPlus2 = {1'b0, pc} + 17'd2;
  assign pcWrap  = pcPlus2[16];

  // No request while reset is held, even though the reset state is FETCH.
  assign imemRd   = rst_n && (state == FETCH);
  assign imemAddr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      instrOut   <= NOP_INSTR;
      pcOut      <= 16'h0000;
      instrValid <= 1'b0;
      err        <= 1'b0;
      skidInstr  <= 16'h0000;
      skidPc     <= 16'h0000;
    end else begin
      pc         <= pcNext;
      instrOut   <= instrNext;
      pcOut      <= pcOutNext;
      instrValid <= validNext;
      err        <= errNext;
      skidInstr  <= skidInstrNext;
      skidPc     <= skidPcNext;
    end
  end

  // Priority order: HALTED is terminal, then redirect, then halt, then the per-state behaviour.
  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    instrNext     = instrOut;
    pcOutNext     = pcOut;
    validNext     = instrValid;
    errNext       = err;
    skidInstrNext = skidInstr;
    skidPcNext    = skidPc;

    if (state == HALTED) begin
      stateNext = HALTED;
    end else if (redirect) begin
      pcNext        = redirectPc;
      instrNext     = NOP_INSTR;
      pcOutNext     = 16'h0000;
      validNext     = 1'b0;
      skidInstrNext = 16'h0000;
      skidPcNext    = 16'h0000;
      if (redirectPc[0]) begin
        errNext = 1'b1;
      end
      // An access still in flight must have its late response discarded.
      if (((state == FETCH) || (state == DROP)) && !imemDone) begin
        stateNext = DROP;
      end else begin
        stateNext = FETCH;
      end
    end else if (halt && !stall) begin
      stateNext     = HALTED;
      instrNext     = NOP_INSTR;
      pcOutNext     = 16'h0000;
      validNext     = 1'b0;
      skidInstrNext = 16'h0000;
      skidPcNext    = 16'h0000;
    end else begin
      case (state)
        FETCH: begin
          if (imemDone) begin
            pcNext = pcPlus2[15:0];
            if (pcWrap) begin
              errNext = 1'b1;
            end
            if (stall) begin
              skidInstrNext = imemData;
              skidPcNext    = pcPlus2[15:0];
              stateNext     = BUF;
            end else begin
              instrNext = imemData;
              pcOutNext = pcPlus2[15:0];
              validNext = 1'b1;
            end
          end else if (!stall) begin
            instrNext = NOP_INSTR;
            pcOutNext = 16'h0000;
            validNext = 1'b0;
          end
        end
        BUF: begin
          if (!stall) begin
            instrNext     = skidInstr;
            pcOutNext     = skidPc;
            validNext     = 1'b1;
            skidInstrNext = 16'h0000;
            skidPcNext    = 16'h0000;
            stateNext     = FETCH;
          end
        end
        DROP: begin
          if (imemDone) begin
            stateNext = FETCH;
          end
        end
        default: begin
          stateNext = state;
        end
      endcase
    end
  end

endmodule
